conv_mc_engine: RTL and testbench
=================================

Name: conv_mc_engine

Overview:
- Multi-channel, parametrised successor to the single-channel 3x3 convolution block in the CNN accelerator datapath.
- Computes all CH_OUT output feature maps from a CH_IN-channel input feature map.
- Supports per-output-channel bias, runtime requantisation shift, optional ReLU and saturation.
- Emits one output pixel at a time on a valid/ready stream, so the downstream pooling stage or buffer can apply backpressure.

Parameters:
DATA_WIDTH, 8, pixel/weight/output width
IFMAP_SIZE, 8, input feature map height = width
KERNEL_SIZE, 3, kernel height = width
CH_IN, 4, input channels
CH_OUT, 4, output channels
STRIDE, 1, window step (1 or 2)
PADDING, 1, zero-padding on each border
SHIFT_WIDTH, 5, width of the requant shift field
OFMAP_SIZE, (IFMAP_SIZE+2*PADDING-KERNEL_SIZE)/STRIDE+1, derived; not overridable
ACC_WIDTH, 2*DATA_WIDTH+$clog2(KERNEL_SIZE*KERNEL_SIZE*CH_IN)+2, derived accumulator width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a full convolution
relu_en  in  1  1 = ReLU, unsigned output; 0 = signed saturated output
shift  in  SHIFT_WIDTH  arithmetic right shift applied after bias
ifmap  in  DATA_WIDTH x [CH_IN][IFMAP_SIZE][IFMAP_SIZE]  unsigned pixels
weights  in  signed DATA_WIDTH x [CH_OUT][CH_IN][KERNEL_SIZE][KERNEL_SIZE]
bias  in  signed ACC_WIDTH x [CH_OUT]
out_valid  out  1  out_data/tags valid
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH  output pixel
out_ch  out  $clog2(CH_OUT)  output channel tag
out_row  out  $clog2(OFMAP_SIZE)  output row tag
out_col  out  $clog2(OFMAP_SIZE)  output column tag
busy  out  1  high in ACCUM or EMIT
done  out  1  level, high in DONE until next accepted start

Behaviour:
- Reset (async, reset_n=0): state IDLE; all counters and the accumulator are 0; out_valid=0, out_data=0, tags=0, busy=0, done=0. A reset asserted mid-operation abandons the run with no further output.
- FSM states: IDLE, ACCUM, EMIT, DONE.
  - IDLE/DONE + start -> ACCUM. Accepting start latches relu_en and shift, clears counters and clears done.
  - start in ACCUM or EMIT is ignored.
- Ordering: out_ch outermost, then row, then col. The input-channel counter ich is innermost.
- ACCUM: one input channel per cycle, for CH_IN cycles.
  - Each cycle computes the full KxK signed MAC of the window against weights[och][ich]. Pixels are zero-extended to DATA_WIDTH+1 before multiplying.
  - Window origin = (row*STRIDE-PADDING, col*STRIDE-PADDING). Taps outside 0..IFMAP_SIZE-1 contribute 0.
  - At ich=0, acc <= bias[och] + mac. Otherwise acc <= acc + mac.
  - After the ich=CH_IN-1 cycle, move to EMIT with out_data and tags registered.
- Post-process, computed on the final accumulator value:
  - v = acc >>> shift (arithmetic, truncation toward minus infinity).
  - relu_en=1: v<0 -> 0; v>2^DATA_WIDTH-1 -> 2^DATA_WIDTH-1; else v.
  - relu_en=0: saturate to signed range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], output as two's complement.
- EMIT: out_valid=1. out_data and tags are held stable until out_ready=1.
  - On handshake (out_valid & out_ready), advance col, then row, then och.
  - Last pixel (och=CH_OUT-1, row=col=OFMAP_SIZE-1) -> DONE, with out_valid dropping the next cycle. Otherwise -> ACCUM.
- Latency: start accepted at edge 0; out_valid first high CH_IN cycles after the state enters ACCUM. With out_ready tied high, total run = CH_OUT*OFMAP_SIZE^2*(CH_IN+1) cycles, then done=1.
- ifmap, weights and bias must be stable from start acceptance until done. The block does not capture them.
- No width overflow: ACC_WIDTH covers the worst-case sum plus bias headroom. shift >= ACC_WIDTH yields 0 or -1.

Test Plan:
- Defaults; all pixels 1, all weights 1, bias 0, shift 0, relu_en=1, out_ready=1 -> interior pixels 36, corners 16, edges 24 (e.g. ch0 (0,0)=16, (0,1)=24, (1,1)=36); 4x8x8 = 256 outputs in 1280 cycles; done=1.
- All weights -1, relu_en=1 -> every out_data=0. Same with relu_en=0 -> interior -36 (0xDC), corner -16 (0xF0).
- Pixels 255, weights 127, bias 0, shift 0, relu_en=1 -> interior pixels saturate to 255. With shift=12 -> interior = (255*127*36)>>12 = 284 -> saturates to 255. With shift=14 -> 71.
- bias[2]=-10, all other bias 0, pixels 0 -> ch2 outputs 0 with relu_en=1, 0xF6 with relu_en=0; other channels 0.
- out_ready toggled pseudo-randomly with 30% stalls -> out_data and tags stable while stalled; no output lost or duplicated; tag sequence matches the och/row/col ordering.
- STRIDE=2 build (OFMAP_SIZE=4); reset_n pulsed low mid-EMIT; start pulsed during busy -> stride-2 indexing correct; after reset, out_valid=0 and busy=0 immediately; a new start gives a full, correct run; the mid-run start is ignored.

Source files
------------

// File: rtl/conv_mc_out_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_mc_out_if
// Brief    : Output pixel stream (valid/ready, data plus och/row/col tags).
// Revision : 1.0
// ============================================================================
interface conv_mc_out_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CH_OUT     = 4,
    parameter int OFMAP_SIZE = 8
);
    localparam int CH_W  = (CH_OUT > 1) ? $clog2(CH_OUT) : 1;
    localparam int POS_W = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CH_W-1:0]       out_ch;
    logic [POS_W-1:0]      out_row;
    logic [POS_W-1:0]      out_col;

    modport master (output out_valid, out_data, out_ch, out_row, out_col, input out_ready);
    modport slave  (input out_valid, out_data, out_ch, out_row, out_col, output out_ready);
endinterface
`default_nettype wire

// File: rtl/conv_mc_engine.sv
`default_nettype none
// ============================================================================
// Module   : conv_mc_engine
// Brief    : Multi-channel KxK convolution, one input channel per cycle,
//            bias + requant shift + ReLU/saturation, streamed output pixels.
// Revision : 1.0
// ============================================================================
module conv_mc_engine #(
    parameter int  DATA_WIDTH  = 8,
    parameter int  IFMAP_SIZE  = 8,
    parameter int  KERNEL_SIZE = 3,
    parameter int  CH_IN       = 4,
    parameter int  CH_OUT      = 4,
    parameter int  STRIDE      = 1,
    parameter int  PADDING     = 1,
    parameter int  SHIFT_WIDTH = 5,
    localparam int OFMAP_SIZE  = (IFMAP_SIZE + 2*PADDING - KERNEL_SIZE)/STRIDE + 1,
    localparam int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(KERNEL_SIZE*KERNEL_SIZE*CH_IN) + 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   relu_en,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [CH_IN-1:0][IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][DATA_WIDTH-1:0]            ifmap,
    input  logic [CH_OUT-1:0][CH_IN-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] weights,
    input  logic [CH_OUT-1:0][ACC_WIDTH-1:0]                                          bias,
    conv_mc_out_if.master          out_if,
    output logic                   busy,
    output logic                   done
);
    localparam int CH_W   = (CH_OUT > 1) ? $clog2(CH_OUT) : 1;
    localparam int POS_W  = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1;
    localparam int ICH_W  = (CH_IN > 1) ? $clog2(CH_IN) : 1;
    localparam int IDX_W  = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
    localparam int PROD_W = 2*DATA_WIDTH + 1;

    localparam logic [CH_W-1:0]  OCH_LAST = CH_W'(CH_OUT - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(OFMAP_SIZE - 1);
    localparam logic [ICH_W-1:0] ICH_LAST = ICH_W'(CH_IN - 1);
    localparam logic signed [ACC_WIDTH-1:0] U_MAX = ACC_WIDTH'((1 << DATA_WIDTH) - 1);
    localparam logic signed [ACC_WIDTH-1:0] S_MAX = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] S_MIN = ~S_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [CH_W-1:0]               och_q, och_d;
    logic [POS_W-1:0]              row_q, row_d, col_q, col_d;
    logic [ICH_W-1:0]              ich_q, ich_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
    logic                          out_valid_q, out_valid_d;
    logic                          busy_q, busy_d, done_q, done_d;
    logic                          relu_q, relu_d;
    logic [SHIFT_WIDTH-1:0]        shift_q, shift_d;

    logic signed [ACC_WIDTH-1:0]   mac, acc_sum, shifted;
    logic [DATA_WIDTH-1:0]         pix_out;

    // KxK window MAC for the current (och, ich); padded taps contribute zero.
    always_comb begin
        int                 y;
        int                 x;
        logic signed [PROD_W-1:0] prod;
        mac = '0;
        for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
            for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
                y    = int'(row_q)*STRIDE - PADDING + ky;
                x    = int'(col_q)*STRIDE - PADDING + kx;
                prod = '0;
                if (y >= 0 && y < IFMAP_SIZE && x >= 0 && x < IFMAP_SIZE)
                    prod = PROD_W'($signed({1'b0, ifmap[ich_q][y[IDX_W-1:0]][x[IDX_W-1:0]]}))
                         * PROD_W'($signed(weights[och_q][ich_q][ky][kx]));
                mac = mac + ACC_WIDTH'(prod);
            end
        end
    end

    always_comb begin
        acc_sum = ((ich_q == '0) ? $signed(bias[och_q]) : acc_q) + mac;
        shifted = acc_sum >>> shift_q;
        if (relu_q) begin
            if (shifted[ACC_WIDTH-1])  pix_out = '0;
            else if (shifted > U_MAX)  pix_out = {DATA_WIDTH{1'b1}};
            else                       pix_out = shifted[DATA_WIDTH-1:0];
        end else begin
            if (shifted > S_MAX)       pix_out = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            else if (shifted < S_MIN)  pix_out = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            else                       pix_out = shifted[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        och_d      = och_q;
        row_d      = row_q;
        col_d      = col_q;
        ich_d      = ich_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        relu_d     = relu_q;
        shift_d    = shift_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    och_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    ich_d   = '0;
                    relu_d  = relu_en;
                    shift_d = shift;
                end
            end
            S_ACCUM: begin
                acc_d = acc_sum;
                if (ich_q == ICH_LAST) begin
                    ich_d      = '0;
                    out_data_d = pix_out;
                    state_d    = S_EMIT;
                end else begin
                    ich_d = ich_q + ICH_W'(1);
                end
            end
            S_EMIT: begin
                if (out_if.out_ready) begin
                    if (och_q == OCH_LAST && row_q == POS_LAST && col_q == POS_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                        if (col_q == POS_LAST) begin
                            col_d = '0;
                            if (row_q == POS_LAST) begin
                                row_d = '0;
                                och_d = och_q + CH_W'(1);
                            end else begin
                                row_d = row_q + POS_W'(1);
                            end
                        end else begin
                            col_d = col_q + POS_W'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d      = (state_d == S_ACCUM) || (state_d == S_EMIT);
        done_d      = (state_d == S_DONE);
        out_valid_d = (state_d == S_EMIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            och_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            ich_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            relu_q      <= 1'b0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            och_q       <= och_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ich_q       <= ich_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            relu_q      <= relu_d;
            shift_q     <= shift_d;
        end
    end

    // Tags are the position counters themselves; they only move on handshake.
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_ch    = och_q;
    assign out_if.out_row   = row_q;
    assign out_if.out_col   = col_q;
    assign busy             = busy_q;
    assign done             = done_q;
endmodule
`default_nettype wire

// File: tb/tb_conv_mc_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_mc_engine
// Brief    : Self-checking bench for conv_mc_engine (stride 1 and stride 2).
// Revision : 1.0
// ============================================================================
module tb_conv_mc_engine;
    localparam int DW   = 8;
    localparam int IFS  = 8;
    localparam int K    = 3;
    localparam int CI   = 4;
    localparam int CO   = 4;
    localparam int PAD  = 1;
    localparam int SW   = 5;
    localparam int ACCW = 2*DW + $clog2(K*K*CI) + 2;
    localparam int OF_A = (IFS + 2*PAD - K)/1 + 1;
    localparam int OF_B = (IFS + 2*PAD - K)/2 + 1;

    typedef struct {
        int         ch;
        int         row;
        int         col;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          start, sel, relu_en, ready;
    logic [SW-1:0] shift;
    logic [CI-1:0][IFS-1:0][IFS-1:0][DW-1:0]   ifmap;
    logic [CO-1:0][CI-1:0][K-1:0][K-1:0][DW-1:0] weights;
    logic [CO-1:0][ACCW-1:0]                   bias;
    logic busy_a, done_a, busy_b, done_b;
    logic start_a, start_b;

    int n_vec = 0;
    int n_err = 0;

    conv_mc_out_if #(.DATA_WIDTH(DW), .CH_OUT(CO), .OFMAP_SIZE(OF_A)) if_a ();
    conv_mc_out_if #(.DATA_WIDTH(DW), .CH_OUT(CO), .OFMAP_SIZE(OF_B)) if_b ();

    assign if_a.out_ready = ready;
    assign if_b.out_ready = ready;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    conv_mc_engine #(.STRIDE(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .relu_en(relu_en), .shift(shift),
        .ifmap(ifmap), .weights(weights), .bias(bias), .out_if(if_a),
        .busy(busy_a), .done(done_a));

    conv_mc_engine #(.STRIDE(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .relu_en(relu_en), .shift(shift),
        .ifmap(ifmap), .weights(weights), .bias(bias), .out_if(if_b),
        .busy(busy_b), .done(done_b));

    logic       w_valid, w_busy, w_done;
    logic [7:0] w_data, w_ch, w_row, w_col;
    always_comb begin
        w_valid = sel ? if_b.out_valid : if_a.out_valid;
        w_busy  = sel ? busy_b : busy_a;
        w_done  = sel ? done_b : done_a;
        w_data  = sel ? if_b.out_data : if_a.out_data;
        w_ch    = sel ? 8'(if_b.out_ch)  : 8'(if_a.out_ch);
        w_row   = sel ? 8'(if_b.out_row) : 8'(if_a.out_row);
        w_col   = sel ? 8'(if_b.out_col) : 8'(if_a.out_col);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Direct convolution from the arithmetic definition.
    function automatic logic [7:0] ref_pix(int stride, int och, int r, int c, logic relu, int sh);
        longint acc = longint'($signed(bias[och]));
        longint v;
        for (int i = 0; i < CI; i++)
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++) begin
                    int y = r*stride - PAD + ky;
                    int x = c*stride - PAD + kx;
                    if (y >= 0 && y < IFS && x >= 0 && x < IFS)
                        acc += longint'(ifmap[i][y][x]) * longint'($signed(weights[och][i][ky][kx]));
                end
        v = acc >>> sh;
        if (relu) begin
            if (v < 0) v = 0;
            if (v > 255) v = 255;
        end else begin
            if (v < -128) v = -128;
            if (v > 127) v = 127;
        end
        return v[7:0];
    endfunction

    task automatic fill_const(input logic [7:0] pix, input logic [7:0] w);
        for (int i = 0; i < CI; i++)
            for (int y = 0; y < IFS; y++)
                for (int x = 0; x < IFS; x++) ifmap[i][y][x] = pix;
        for (int o = 0; o < CO; o++)
            for (int i = 0; i < CI; i++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++) weights[o][i][ky][kx] = w;
        bias = '0;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < CI; i++)
            for (int y = 0; y < IFS; y++)
                for (int x = 0; x < IFS; x++) ifmap[i][y][x] = 8'($urandom);
        for (int o = 0; o < CO; o++) begin
            for (int i = 0; i < CI; i++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++) weights[o][i][ky][kx] = 8'($urandom);
            bias[o] = ACCW'(int'($urandom_range(0, 40000)) - 20000);
        end
    endtask

    task automatic run(input bit use_b, input bit relu, input int sh, input int stall_pct, input int mid_start);
        exp_t        q[$];
        exp_t        e;
        int          of     = use_b ? OF_B : OF_A;
        int          stride = use_b ? 2 : 1;
        int          limit  = 40000;
        int          cyc    = 0;
        bit          stalled = 1'b0;
        logic [31:0] held = '0;
        for (int o = 0; o < CO; o++)
            for (int r = 0; r < of; r++)
                for (int c = 0; c < of; c++) begin
                    e.ch = o; e.row = r; e.col = c;
                    e.d  = ref_pix(stride, o, r, c, relu, sh);
                    q.push_back(e);
                end
        sel = use_b; relu_en = relu; shift = SW'(sh); ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (1) begin
            start = (cyc == mid_start);
            if (stalled) begin
                check("stall_valid", 32'(w_valid), 32'd1);
                check("stall_hold", {w_ch, w_row, w_col, w_data}, held);
            end
            if (w_done) break;
            if (cyc > limit) begin
                check("run_timeout", 32'(w_done), 32'd1);
                break;
            end
            ready   = ($urandom_range(0, 99) >= stall_pct);
            stalled = 1'b0;
            if (w_valid) begin
                if (ready) begin
                    if (q.size() == 0) begin
                        check("extra_output", 32'd1, 32'd0 + 32'(q.size()));
                    end else begin
                        e = q.pop_front();
                        check("data", 32'(w_data), 32'(e.d));
                        check("tags", {8'd0, w_ch, w_row, w_col}, {8'd0, 8'(e.ch), 8'(e.row), 8'(e.col)});
                    end
                end else begin
                    stalled = 1'b1;
                    held    = {w_ch, w_row, w_col, w_data};
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("missing_outputs", 32'(q.size()), 32'd0);
        check("end_idle", {30'd0, w_valid, w_busy}, 32'd0);
        if (stall_pct == 0 && mid_start < 0)
            check("run_cycles", 32'(cyc), 32'(CO*of*of*(CI+1)));
        ready = 1'b0;
    endtask

    initial begin
        start = 1'b0; sel = 1'b0; relu_en = 1'b0; ready = 1'b0; shift = '0;
        fill_const(8'd0, 8'd0);
        repeat (3) @(negedge clk);
        check("rst_a_state", {29'd0, if_a.out_valid, busy_a, done_a}, 32'd0);
        check("rst_a_out", {if_a.out_data, 8'(if_a.out_ch), 8'(if_a.out_row), 8'(if_a.out_col)}, 32'd0);
        check("rst_b_state", {29'd0, if_b.out_valid, busy_b, done_b}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        fill_const(8'd1, 8'd1);        run(0, 1, 0, 0, -1);
        fill_const(8'd1, 8'hFF);       run(0, 1, 0, 0, -1);
        run(0, 0, 0, 0, -1);
        fill_const(8'd255, 8'd127);    run(0, 1, 0, 0, -1);
        run(0, 1, 12, 0, -1);
        run(0, 1, 14, 0, -1);
        fill_const(8'd0, 8'd5);
        bias[2] = ACCW'(-10);          run(0, 1, 0, 0, -1);
        run(0, 0, 0, 0, -1);
        fill_rand();                   run(0, 1, 8, 30, -1);
        fill_rand();                   run(0, 0, 10, 30, -1);
        fill_rand();                   run(0, 0, 28, 30, -1);
        fill_rand();                   run(1, 1, 9, 0, -1);

        // Abort a stride-2 run while it is holding a pixel in EMIT.
        fill_rand();
        sel = 1'b1; relu_en = 1'b1; shift = SW'(8); ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20 && !w_valid; i++) @(negedge clk);
        check("emit_reached", 32'(w_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst", {w_data, 21'd0, w_valid, w_busy, w_done}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {29'd0, w_valid, w_busy, w_done}, 32'd0);
        run(1, 0, 9, 30, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
